// File: rtl/pipe_pkg.sv
// Shared defaults and helpers for the valid/ready register pipeline.
package pipe_pkg;

  localparam int P_NBITS_DEF   = 8;
  localparam int P_NSTAGES_DEF = 2;

  // Bits needed to hold a stage population count of 0..nstages.
  function automatic int cnt_w(input int nstages);
    return (nstages < 1) ? 1 : $clog2(nstages + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: valid/data register that advances whenever it is empty
// or the slot downstream can take its contents.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int p_nbits = P_NBITS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prev_val,
  input  logic [p_nbits-1:0] prev_msg,
  input  logic               next_rdy,
  output logic               rdy,
  output logic               val,
  output logic [p_nbits-1:0] msg
);

  assign rdy = !val || next_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      val <= 1'b0;
      msg <= '0;
    end else if (rdy) begin
      val <= prev_val;
      msg <= prev_msg;
    end
  end

endmodule

// File: rtl/pipe_reg.sv
// Bubble-collapsing valid/ready register pipeline of p_nstages slots with a
// combinational ready chain from out_rdy back to in_rdy.
module pipe_reg
  import pipe_pkg::*;
#(
  parameter int p_nbits   = P_NBITS_DEF,
  parameter int p_nstages = P_NSTAGES_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_val,
  output logic                          in_rdy,
  input  logic [p_nbits-1:0]            in_msg,
  output logic                          out_val,
  input  logic                          out_rdy,
  output logic [p_nbits-1:0]            out_msg,
  output logic [cnt_w(p_nstages)-1:0]   count
);

  if (p_nstages < 1 || p_nbits < 1) begin : g_bad_param
    $error("pipe_reg: p_nstages and p_nbits must both be >= 1");
  end

  // Index 0 is the upstream port; index i is the output of stage i-1.
  logic [p_nstages:0]              vld_pipe;
  logic [p_nstages:0][p_nbits-1:0] dat_pipe;
  logic [p_nstages-1:0]            rdy_stg;
  logic [p_nstages-1:0]            nxt_rdy;
  logic                            unused_rdy;

  assign vld_pipe[0] = in_val;
  assign dat_pipe[0] = in_msg;

  // Stage i may advance if anything downstream of it has a hole or the sink
  // drains; built from valid bits so the chain has no self-referencing net.
  always_comb begin
    nxt_rdy = '0;
    nxt_rdy[p_nstages-1] = out_rdy;
    for (int i = p_nstages - 2; i >= 0; i--)
      nxt_rdy[i] = nxt_rdy[i+1] | ~vld_pipe[i+2];
  end

  for (genvar g = 0; g < p_nstages; g++) begin : g_stg
    pipe_stage #(.p_nbits(p_nbits)) u_stg (
      .clk      (clk),
      .reset    (reset),
      .prev_val (vld_pipe[g]),
      .prev_msg (dat_pipe[g]),
      .next_rdy (nxt_rdy[g]),
      .rdy      (rdy_stg[g]),
      .val      (vld_pipe[g+1]),
      .msg      (dat_pipe[g+1])
    );
  end

  assign in_rdy     = rdy_stg[0];
  assign out_val    = vld_pipe[p_nstages];
  assign out_msg    = dat_pipe[p_nstages];
  assign unused_rdy = ^rdy_stg;

  always_comb begin
    count = '0;
    for (int i = 1; i <= p_nstages; i++)
      count = count + cnt_w(p_nstages)'(vld_pipe[i]);
  end

`ifdef FORMAL
  // Ghost sequence numbers ride alongside the data to prove in-order delivery.
  logic [31:0] in_seq, out_seq;
  logic [31:0] tag [1:p_nstages];

  always_ff @(posedge clk) begin
    if (reset) begin
      in_seq  <= '0;
      out_seq <= '0;
      for (int i = 1; i <= p_nstages; i++) tag[i] <= '0;
    end else begin
      if (in_val && in_rdy)   in_seq  <= in_seq + 32'd1;
      if (out_val && out_rdy) out_seq <= out_seq + 32'd1;
      for (int i = 1; i <= p_nstages; i++)
        if (rdy_stg[i-1]) tag[i] <= (i == 1) ? in_seq : tag[(i == 1) ? 1 : i-1];
    end
  end

  a_hold:  assert property (@(posedge clk) disable iff (reset)
                            out_val && !out_rdy |=> out_val && $stable(out_msg));
  a_cnt:   assert property (@(posedge clk) count <= p_nstages);
  a_order: assert property (@(posedge clk) disable iff (reset)
                            out_val && out_rdy |-> tag[p_nstages] == out_seq);
`endif

endmodule
